// File: rtl/sdram_burst_master_pkg.sv
// Shared SDRAM parameters and burst-master state encodings.
package sdram_burst_master_pkg;

    localparam int SDR_ASIZE     = 23;
    localparam int SDR_DSIZE     = 16;
    localparam int SDR_BURST_LEN = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RELEASE
    } state_e;

endpackage

// File: rtl/sdram_burst_master_line_buf.sv
// One-line buffer: synchronous write port, asynchronous read port.
module sdram_line_buf #(
    parameter int DEPTH = 8,
    parameter int W     = 16,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sdram_burst_master.sv
// Host-side initiator for the SDRAM controller WR/RD/LENGTH/DONE handshake,
// buffering one write line and one read line.
module sdram_burst_master
    import sdram_burst_master_pkg::*;
#(
    parameter int ASIZE     = SDR_ASIZE,
    parameter int DSIZE     = SDR_DSIZE,
    parameter int BURST_LEN = SDR_BURST_LEN,
    parameter int IDXW      = 3,
    parameter int RD_SKEW   = 0,
    parameter int GAP       = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               cmd_valid_i,
    input  logic               cmd_write_i,
    input  logic [ASIZE-1:0]   cmd_addr_i,
    output logic               cmd_ready_o,
    output logic               cmd_done_o,
    output logic               cmd_err_o,
    input  logic               wb_we_i,
    input  logic [IDXW-1:0]    wb_idx_i,
    input  logic [DSIZE-1:0]   wb_data_i,
    input  logic [DSIZE/8-1:0] wb_dm_i,
    input  logic [IDXW-1:0]    rb_idx_i,
    output logic [DSIZE-1:0]   rb_data_o,
    output logic [ASIZE-1:0]   addr_o,
    output logic               wr_o,
    output logic               rd_o,
    output logic [7:0]         length_o,
    output logic [DSIZE-1:0]   datain_o,
    output logic [DSIZE/8-1:0] dm_o,
    input  logic               act_i,
    input  logic               done_i,
    input  logic               in_req_i,
    input  logic               out_valid_i,
    input  logic [DSIZE-1:0]   dataout_i
);

    localparam int DMW = DSIZE / 8;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GAP + 1);
    localparam logic [IDXW:0] RLEN = (IDXW + 1)'(BURST_LEN);
    localparam logic [IDXW-1:0] WLAST = IDXW'(BURST_LEN - 1);

    state_e           state_q, state_d;
    logic [ASIZE-1:0] addr_q, addr_d;
    logic             write_q, write_d;
    logic             err_q, err_d;
    logic [IDXW-1:0]  wcnt_q, wcnt_d;
    logic [IDXW:0]    rcnt_q, rcnt_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [DSIZE-1:0] rb_data_q;

    logic             busy, req_lvl, cap;
    logic             wbuf_we, rbuf_we;
    logic [DSIZE-1:0] wb_word;
    logic [DMW-1:0]   wb_mask;
    logic [DSIZE-1:0] rb_word;

    // Controller busy is informational only.
    logic unused_ok;
    assign unused_ok = act_i;

    generate
        if (RD_SKEW == 0) begin : g_noskew
            assign cap = out_valid_i;
        end else begin : g_skew
            logic [RD_SKEW-1:0] skew_q;
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) skew_q <= '0;
                else            skew_q <= (skew_q << 1) | RD_SKEW'(out_valid_i);
            end
            assign cap = skew_q[RD_SKEW-1];
        end
    endgenerate

    assign busy    = (state_q != ST_IDLE);
    assign req_lvl = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign wbuf_we = wb_we_i && !(busy && write_q);
    assign rbuf_we = busy && !write_q && cap && (rcnt_q < RLEN);

    sdram_line_buf #(.DEPTH(BURST_LEN), .W(DSIZE + DMW), .AW(IDXW)) u_wbuf (
        .clk_i   (clk_i),
        .we_i    (wbuf_we),
        .waddr_i (wb_idx_i),
        .wdata_i ({wb_dm_i, wb_data_i}),
        .raddr_i (wcnt_q),
        .rdata_o ({wb_mask, wb_word})
    );

    sdram_line_buf #(.DEPTH(BURST_LEN), .W(DSIZE), .AW(IDXW)) u_rbuf (
        .clk_i   (clk_i),
        .we_i    (rbuf_we),
        .waddr_i (rcnt_q[IDXW-1:0]),
        .wdata_i (dataout_i),
        .raddr_i (rb_idx_i),
        .rdata_o (rb_word)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            wdog_q    <= '0;
            gap_q     <= '0;
            rb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            wdog_q    <= wdog_d;
            gap_q     <= gap_d;
            rb_data_q <= rb_word;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        wdog_d  = wdog_q;
        gap_d   = gap_q;

        if (busy && write_q && in_req_i && (wcnt_q != WLAST)) begin
            wcnt_d = wcnt_q + IDXW'(1);
        end
        if (rbuf_we) begin
            rcnt_d = rcnt_q + (IDXW + 1)'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    write_d = cmd_write_i;
                    err_d   = 1'b0;
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // DONE takes priority over a coincident watchdog expiry.
                if (done_i) begin
                    gap_d   = '0;
                    state_d = ST_RELEASE;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            ST_RELEASE: begin
                if (gap_q == GW'(GAP - 1)) state_d = ST_IDLE;
                else                       gap_d   = gap_q + GW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign cmd_done_o  = (state_q == ST_RELEASE) && (gap_q == GW'(GAP - 1));
    assign cmd_err_o   = cmd_done_o && err_q;
    assign addr_o      = addr_q;
    assign wr_o        = req_lvl && write_q;
    assign rd_o        = req_lvl && !write_q;
    assign length_o    = 8'(BURST_LEN);
    assign datain_o    = (busy && write_q) ? wb_word : '0;
    assign dm_o        = (busy && write_q) ? wb_mask : '0;
    assign rb_data_o   = rb_data_q;

endmodule
